adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, carry-split pipelined adder for the ChaCha20 datapath; next generation of the single-register 32-bit adder.
- Processes LANES independent words per beat, e.g. all 16 state words for the final state-add.
- Operation is per beat: modular add (mod 2^DATA_WIDTH) or XOR.
- Carry chain is split into CHUNK_WIDTH-bit pipeline stages to close timing.
- Valid/ready streaming handshake on both sides; pipeline stalls under backpressure and collapses bubbles.

Parameters:
DATA_WIDTH, 32, width of one lane word in bits
LANES, 16, number of independent words processed per beat
CHUNK_WIDTH, 16, bits added per pipeline stage; STAGES = DATA_WIDTH/CHUNK_WIDTH

Ports:
i_aclk  in  1  clock
i_aresetn  in  1  asynchronous active-low reset
i_s_valid  in  1  input beat valid
o_s_ready  out  1  block can accept input beat this cycle
i_s_op  in  1  0 = ADD mod 2^DATA_WIDTH, 1 = XOR
i_s_a  in  LANES*DATA_WIDTH  operand A; lane n = bits [n*DATA_WIDTH +: DATA_WIDTH]
i_s_b  in  LANES*DATA_WIDTH  operand B, same packing
i_s_last  in  1  sideband, passed through unchanged
o_m_valid  out  1  output beat valid
i_m_ready  in  1  downstream accepts output beat
o_m_data  out  LANES*DATA_WIDTH  result, same lane packing
o_m_carry  out  LANES  carry-out of each lane's MSB; 0 for XOR
o_m_last  out  1  i_s_last of this beat

Behaviour:
- Legal parameters: DATA_WIDTH % CHUNK_WIDTH == 0, CHUNK_WIDTH >= 1, LANES >= 1.
- Illegal parameters trigger an elaboration-time error.
- Reset is asynchronous on falling i_aresetn and applies to every stage.
- Reset state: all stage valid flags 0, all data/carry/last/op registers 0.
- Reset outputs: o_m_valid=0, o_m_data=0, o_m_carry=0, o_m_last=0, o_s_ready=1.
- Input transfer occurs when i_s_valid && o_s_ready at a rising edge.
- Output transfer occurs when o_m_valid && i_m_ready at a rising edge.
- Pipeline is STAGES register stages, stage 0 to stage STAGES-1; the last stage drives the m_* outputs directly.
- Stage k result: lane chunk k is computed as a[chunk k] + b[chunk k] + carry from stage k-1.
- Stage 0 carry-in is 0.
- Result chunks 0..k-1 and operand chunks k+1..STAGES-1 are carried forward in registers alongside.
- Stage k carry register holds chunk k's carry-out.
- XOR: each chunk is a ^ b and all carries are forced to 0.
- Each stage holds its own op bit and last bit.
- Stage load rule: stage k loads when its valid is 0 or stage k+1 loads.
- For the last stage, "stage k+1 loads" means i_m_ready.
- o_s_ready = stage-0 load condition. The combinational path i_m_ready -> o_s_ready is permitted.
- A stage that loads while its predecessor holds no valid beat clears its own valid, so bubbles collapse.
- Latency: STAGES cycles from input transfer to o_m_valid with no backpressure.
- Throughput: 1 beat per cycle sustained.
- CHUNK_WIDTH == DATA_WIDTH gives 1 stage and latency 1, equivalent to the legacy registered adder.
- While o_m_valid=1 and i_m_ready=0: o_m_data, o_m_carry and o_m_last hold stable.
- Beats are never dropped or duplicated; order is preserved.
- Capacity: maximum STAGES beats in flight. When all stages are valid and i_m_ready=0, o_s_ready=0.
- Wrap-around: ADD result is the sum mod 2^DATA_WIDTH; carry-out appears on o_m_carry.
- Lanes are fully independent: no carry crosses a lane boundary.
- Reset mid-operation discards all in-flight beats. The first beat accepted after reset release emerges STAGES cycles later.
- i_s_* values are sampled only on transfer; they are don't-care otherwise.

Test Plan:
1. Defaults; lane0 A=0xFFFFFFFF, B=0x00000001 ADD, other lanes 0 -> 2 cycles later o_m_valid=1, lane0=0x00000000, o_m_carry[0]=1, other carries 0; lane1 A=0x0000FFFF, B=1 -> 0x00010000, carry 0 (cross-chunk carry).
2. Stream 8 beats back-to-back with i_m_ready=1, lane n A=n*0x01010101, B=0x10000000, op alternating ADD/XOR -> results out in order one per cycle after 2-cycle latency; XOR beats show carry=0; i_s_last on beat 8 appears only on output beat 8.
3. i_m_ready=0 for 6 cycles with i_s_valid held 1 -> exactly 2 beats accepted, then o_s_ready=0; o_m_data stable; after i_m_ready=1 all beats drain in order with no loss or duplicate.
4. Bubble collapse: accept beat, idle 1 cycle, accept beat, hold i_m_ready=0 -> second beat advances into the empty stage; o_s_ready stays 1 until both stages are valid.
5. Assert i_aresetn=0 with 2 beats in flight -> o_m_valid=0, o_m_data=0, o_m_carry=0, o_s_ready=1 immediately; no stale beat after release; next beat emerges at latency 2.
6. CHUNK_WIDTH=32, LANES=1: 0x80000000+0x80000000 -> 0x00000000, carry 1, latency 1. CHUNK_WIDTH=8: 0x00FFFFFF+1 -> 0x01000000, latency 4.

Source files
------------

// File: rtl/adder_pipe_if.sv
// Streaming bus for adder_pipe: operand beat in on the s side, result beat out on the m side.
// The slave modport is the adder's view; the master modport is the view of whoever drives it.
interface adder_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 16
);
    logic                        i_s_valid;
    logic                        o_s_ready;
    logic                        i_s_op;
    logic [LANES*DATA_WIDTH-1:0] i_s_a;
    logic [LANES*DATA_WIDTH-1:0] i_s_b;
    logic                        i_s_last;
    logic                        o_m_valid;
    logic                        i_m_ready;
    logic [LANES*DATA_WIDTH-1:0] o_m_data;
    logic [LANES-1:0]            o_m_carry;
    logic                        o_m_last;

    modport slave (
        input  i_s_valid, i_s_op, i_s_a, i_s_b, i_s_last, i_m_ready,
        output o_s_ready, o_m_valid, o_m_data, o_m_carry, o_m_last
    );

    modport master (
        output i_s_valid, i_s_op, i_s_a, i_s_b, i_s_last, i_m_ready,
        input  o_s_ready, o_m_valid, o_m_data, o_m_carry, o_m_last
    );
endinterface

// File: rtl/adder_pipe.sv
// Multi-lane add/XOR with the carry chain split into CHUNK_WIDTH-bit pipeline stages.
// Stage k finishes chunk k of every lane; the last stage drives the output beat directly.
module adder_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 16,
    parameter int CHUNK_WIDTH = 16
) (
    input  logic        i_aclk,
    input  logic        i_aresetn,
    adder_pipe_if.slave bus
);
    localparam bit PARAMS_OK = (CHUNK_WIDTH >= 1) && (LANES >= 1) &&
                               (DATA_WIDTH >= CHUNK_WIDTH) &&
                               ((DATA_WIDTH % ((CHUNK_WIDTH >= 1) ? CHUNK_WIDTH : 1)) == 0);
    localparam int STAGES = PARAMS_OK ? DATA_WIDTH / CHUNK_WIDTH : 1;
    localparam int W      = LANES * DATA_WIDTH;

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("adder_pipe: DATA_WIDTH must be a positive multiple of CHUNK_WIDTH, CHUNK_WIDTH >= 1, LANES >= 1");
        end
    endgenerate

    logic [STAGES-1:0] valid_q;
    logic              op_q    [STAGES];
    logic              last_q  [STAGES];
    logic [W-1:0]      dat_q   [STAGES];
    logic [W-1:0]      b_q     [STAGES];
    logic [LANES-1:0]  carry_q [STAGES];

    logic [STAGES-1:0] load;
    logic              src_valid [STAGES];
    logic              src_op    [STAGES];
    logic              src_last  [STAGES];
    logic [W-1:0]      src_dat   [STAGES];
    logic [W-1:0]      src_b     [STAGES];
    logic [LANES-1:0]  src_cin   [STAGES];
    logic [W-1:0]      dat_d     [STAGES];
    logic [LANES-1:0]  carry_d   [STAGES];

    // A stage may load when it or any stage downstream of it is empty, or the sink takes the output.
    always_comb begin
        logic free;
        load = '0;
        for (int k = 0; k < STAGES; k++) begin
            free = 1'b0;
            for (int j = k; j < STAGES; j++) begin
                free = free | ~valid_q[j];
            end
            load[k] = free | bus.i_m_ready;
        end
    end

    // dat carries finished result chunks below k and untouched operand-A chunks above k.
    always_comb begin
        src_valid[0] = bus.i_s_valid;
        src_op[0]    = bus.i_s_op;
        src_last[0]  = bus.i_s_last;
        src_dat[0]   = bus.i_s_a;
        src_b[0]     = bus.i_s_b;
        src_cin[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_op[k]    = op_q[k-1];
            src_last[k]  = last_q[k-1];
            src_dat[k]   = dat_q[k-1];
            src_b[k]     = b_q[k-1];
            src_cin[k]   = carry_q[k-1];
        end
    end

    always_comb begin
        logic [CHUNK_WIDTH:0]   sum;
        logic [CHUNK_WIDTH-1:0] ca;
        logic [CHUNK_WIDTH-1:0] cb;
        sum = '0;
        ca  = '0;
        cb  = '0;
        for (int k = 0; k < STAGES; k++) begin
            dat_d[k]   = src_dat[k];
            carry_d[k] = '0;
            for (int l = 0; l < LANES; l++) begin
                ca  = src_dat[k][l*DATA_WIDTH + k*CHUNK_WIDTH +: CHUNK_WIDTH];
                cb  = src_b[k][l*DATA_WIDTH + k*CHUNK_WIDTH +: CHUNK_WIDTH];
                sum = {1'b0, ca} + {1'b0, cb} + {{CHUNK_WIDTH{1'b0}}, src_cin[k][l]};
                if (src_op[k]) begin
                    dat_d[k][l*DATA_WIDTH + k*CHUNK_WIDTH +: CHUNK_WIDTH] = ca ^ cb;
                    carry_d[k][l] = 1'b0;
                end else begin
                    dat_d[k][l*DATA_WIDTH + k*CHUNK_WIDTH +: CHUNK_WIDTH] = sum[CHUNK_WIDTH-1:0];
                    carry_d[k][l] = sum[CHUNK_WIDTH];
                end
            end
        end
    end

    // Payload registers only move with a real beat; a bubble just clears the valid flag.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                op_q[k]    <= 1'b0;
                last_q[k]  <= 1'b0;
                dat_q[k]   <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        op_q[k]    <= src_op[k];
                        last_q[k]  <= src_last[k];
                        dat_q[k]   <= dat_d[k];
                        b_q[k]     <= src_b[k];
                        carry_q[k] <= carry_d[k];
                    end
                end
            end
        end
    end

    assign bus.o_s_ready = load[0];
    assign bus.o_m_valid = valid_q[STAGES-1];
    assign bus.o_m_data  = dat_q[STAGES-1];
    assign bus.o_m_carry = carry_q[STAGES-1];
    assign bus.o_m_last  = last_q[STAGES-1];
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: default 16-lane/2-stage build plus 1-stage and 4-stage single-lane builds.
module tb_adder_pipe;
    localparam int DW = 32;
    localparam int LN = 16;
    localparam int W  = DW * LN;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    adder_pipe_if #(.DATA_WIDTH(DW), .LANES(LN)) bus   ();
    adder_pipe_if #(.DATA_WIDTH(DW), .LANES(1))  bus32 ();
    adder_pipe_if #(.DATA_WIDTH(DW), .LANES(1))  bus8  ();

    adder_pipe #(.DATA_WIDTH(DW), .LANES(LN), .CHUNK_WIDTH(16)) dut (
        .i_aclk(clk), .i_aresetn(rst_n), .bus(bus));
    adder_pipe #(.DATA_WIDTH(DW), .LANES(1), .CHUNK_WIDTH(32)) dut_c32 (
        .i_aclk(clk), .i_aresetn(rst_n), .bus(bus32));
    adder_pipe #(.DATA_WIDTH(DW), .LANES(1), .CHUNK_WIDTH(8)) dut_c8 (
        .i_aclk(clk), .i_aresetn(rst_n), .bus(bus8));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] lane0(input logic [31:0] v);
        logic [W-1:0] r;
        r = '0;
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] stream_a();
        logic [W-1:0] r;
        for (int n = 0; n < LN; n++) r[n*32 +: 32] = 32'(n) * 32'h01010101;
        return r;
    endfunction

    function automatic logic [W-1:0] stream_b(input int i);
        logic [W-1:0] r;
        for (int n = 0; n < LN; n++) r[n*32 +: 32] = 32'h10000000 + 32'(i);
        return r;
    endfunction

    function automatic logic [W-1:0] stream_exp(input int i);
        logic [W-1:0] r;
        logic [31:0]  a;
        logic [31:0]  b;
        for (int n = 0; n < LN; n++) begin
            a = 32'(n) * 32'h01010101;
            b = 32'h10000000 + 32'(i);
            r[n*32 +: 32] = (i % 2 == 1) ? (a ^ b) : (a + b);
        end
        return r;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.o_m_valid, bus.o_m_last, bus.o_s_ready, bus.o_m_carry} !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL reset_ctl got v=%b l=%b r=%b c=%h expected v=0 l=0 r=1 c=0000",
                     bus.o_m_valid, bus.o_m_last, bus.o_s_ready, bus.o_m_carry);
        end
        checks++;
        if (bus.o_m_data !== '0) begin
            errors++;
            $display("FAIL reset_data got %h expected 0", bus.o_m_data);
        end
        checks++;
        if ({bus32.o_m_valid, bus32.o_s_ready, bus32.o_m_carry, bus32.o_m_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_c32 got v=%b r=%b c=%b d=%h expected v=0 r=1 c=0 d=0",
                     bus32.o_m_valid, bus32.o_s_ready, bus32.o_m_carry, bus32.o_m_data);
        end
        checks++;
        if ({bus8.o_m_valid, bus8.o_s_ready, bus8.o_m_carry, bus8.o_m_data} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_c8 got v=%b r=%b c=%b d=%h expected v=0 r=1 c=0 d=0",
                     bus8.o_m_valid, bus8.o_s_ready, bus8.o_m_carry, bus8.o_m_data);
        end
    endtask

    task automatic test_cross_chunk();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        a = '0; b = '0; e = '0;
        a[31:0]  = 32'hFFFFFFFF; b[31:0]  = 32'h00000001;
        a[63:32] = 32'h0000FFFF; b[63:32] = 32'h00000001;
        e[63:32] = 32'h00010000;
        bus.i_s_a = a; bus.i_s_b = b; bus.i_s_op = 1'b0; bus.i_s_last = 1'b0;
        bus.i_m_ready = 1'b1; bus.i_s_valid = 1'b1;
        #1;
        checks++;
        if (bus.o_s_ready !== 1'b1) begin
            errors++; $display("FAIL cc_ready got %b expected 1", bus.o_s_ready);
        end
        tick();
        bus.i_s_valid = 1'b0; bus.i_s_a = '0; bus.i_s_b = '0;
        checks++;
        if (bus.o_m_valid !== 1'b0) begin
            errors++; $display("FAIL cc_early_valid got %b expected 0", bus.o_m_valid);
        end
        tick();
        checks++;
        if (bus.o_m_valid !== 1'b1) begin
            errors++; $display("FAIL cc_valid got %b expected 1", bus.o_m_valid);
        end
        checks++;
        if (bus.o_m_data !== e) begin
            errors++; $display("FAIL cc_data got %h expected %h", bus.o_m_data, e);
        end
        checks++;
        if (bus.o_m_carry !== 16'h0001) begin
            errors++; $display("FAIL cc_carry got %h expected 0001", bus.o_m_carry);
        end
        tick();
        checks++;
        if (bus.o_m_valid !== 1'b0) begin
            errors++; $display("FAIL cc_drained got %b expected 0", bus.o_m_valid);
        end
    endtask

    task automatic test_back_to_back();
        int o;
        bus.i_m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            o = c - 2;
            checks++;
            if (bus.o_m_valid !== (c >= 2 && c < 10)) begin
                errors++; $display("FAIL b2b_valid cyc=%0d got %b expected %b", c, bus.o_m_valid, (c >= 2 && c < 10));
            end
            if (c >= 2 && c < 10) begin
                checks++;
                if (bus.o_m_data !== stream_exp(o)) begin
                    errors++; $display("FAIL b2b_data beat=%0d got %h expected %h", o, bus.o_m_data, stream_exp(o));
                end
                checks++;
                if ({bus.o_m_carry, bus.o_m_last} !== {16'h0, (o == 7)}) begin
                    errors++; $display("FAIL b2b_carry_last beat=%0d got c=%h l=%b expected c=0000 l=%b",
                                       o, bus.o_m_carry, bus.o_m_last, (o == 7));
                end
            end
            if (c < 8) begin
                bus.i_s_valid = 1'b1;
                bus.i_s_a     = stream_a();
                bus.i_s_b     = stream_b(c);
                bus.i_s_op    = c[0];
                bus.i_s_last  = (c == 7);
                #1;
                checks++;
                if (bus.o_s_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready cyc=%0d got %b expected 1", c, bus.o_s_ready);
                end
            end else begin
                bus.i_s_valid = 1'b0;
                bus.i_s_last  = 1'b0;
                bus.i_s_op    = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        bus.i_m_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c >= 2) begin
                checks++;
                if ({bus.o_m_valid, bus.o_m_data} !== {1'b1, lane0(32'h11110000)}) begin
                    errors++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h expected v=1 lane0=11110000",
                                       c, bus.o_m_valid, bus.o_m_data[31:0]);
                end
            end
            bus.i_s_valid = 1'b1;
            bus.i_s_op    = 1'b0;
            bus.i_s_last  = 1'b0;
            bus.i_s_a     = lane0(32'h11110000);
            bus.i_s_b     = lane0(32'(acc));
            #1;
            if (bus.o_s_ready) acc++;
            tick();
        end
        checks++;
        if (acc !== 2) begin
            errors++; $display("FAIL bp_accepted got %0d expected 2", acc);
        end
        #1;
        checks++;
        if (bus.o_s_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_ready got %b expected 0", bus.o_s_ready);
        end
        bus.i_s_valid = 1'b0;
        bus.i_m_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (bus.o_m_valid !== (d < 2)) begin
                errors++; $display("FAIL bp_drain_valid cyc=%0d got %b expected %b", d, bus.o_m_valid, (d < 2));
            end
            if (d < 2) begin
                checks++;
                if (bus.o_m_data !== lane0(32'h11110000 + 32'(d))) begin
                    errors++; $display("FAIL bp_drain_data cyc=%0d got %h expected lane0=%h",
                                       d, bus.o_m_data[31:0], 32'h11110000 + 32'(d));
                end
            end
            tick();
        end
    endtask

    task automatic test_bubble();
        bus.i_m_ready = 1'b0;
        bus.i_s_op = 1'b0; bus.i_s_last = 1'b0;
        bus.i_s_a = lane0(32'h0000000A); bus.i_s_b = '0; bus.i_s_valid = 1'b1;
        tick();
        bus.i_s_valid = 1'b0;
        tick();
        checks++;
        if ({bus.o_m_valid, bus.o_m_data} !== {1'b1, lane0(32'h0000000A)}) begin
            errors++; $display("FAIL bub_first got v=%b lane0=%h expected v=1 lane0=0000000a",
                               bus.o_m_valid, bus.o_m_data[31:0]);
        end
        bus.i_s_a = lane0(32'h0000000B); bus.i_s_valid = 1'b1;
        #1;
        checks++;
        if (bus.o_s_ready !== 1'b1) begin
            errors++; $display("FAIL bub_ready got %b expected 1", bus.o_s_ready);
        end
        tick();
        bus.i_s_valid = 1'b0;
        #1;
        checks++;
        if (bus.o_s_ready !== 1'b0) begin
            errors++; $display("FAIL bub_full got %b expected 0", bus.o_s_ready);
        end
        bus.i_m_ready = 1'b1;
        tick();
        checks++;
        if ({bus.o_m_valid, bus.o_m_data} !== {1'b1, lane0(32'h0000000B)}) begin
            errors++; $display("FAIL bub_second got v=%b lane0=%h expected v=1 lane0=0000000b",
                               bus.o_m_valid, bus.o_m_data[31:0]);
        end
        tick();
        checks++;
        if (bus.o_m_valid !== 1'b0) begin
            errors++; $display("FAIL bub_empty got %b expected 0", bus.o_m_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_m_ready = 1'b0;
        bus.i_s_op = 1'b0; bus.i_s_last = 1'b1;
        bus.i_s_a = lane0(32'hFFFFFFFF); bus.i_s_b = lane0(32'h00000001); bus.i_s_valid = 1'b1;
        tick();
        tick();
        bus.i_s_valid = 1'b0; bus.i_s_last = 1'b0;
        checks++;
        if ({bus.o_m_valid, bus.o_m_carry[0], bus.o_m_last} !== 3'b111) begin
            errors++; $display("FAIL rm_pre got v=%b c0=%b l=%b expected 111",
                               bus.o_m_valid, bus.o_m_carry[0], bus.o_m_last);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_m_valid, bus.o_m_last, bus.o_s_ready, bus.o_m_carry} !== {1'b0, 1'b0, 1'b1, 16'h0}) begin
            errors++; $display("FAIL rm_ctl got v=%b l=%b r=%b c=%h expected v=0 l=0 r=1 c=0000",
                               bus.o_m_valid, bus.o_m_last, bus.o_s_ready, bus.o_m_carry);
        end
        checks++;
        if (bus.o_m_data !== '0) begin
            errors++; $display("FAIL rm_data got %h expected 0", bus.o_m_data);
        end
        tick();
        rst_n = 1'b1;
        bus.i_m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.o_m_valid !== 1'b0) begin
                errors++; $display("FAIL rm_stale cyc=%0d got %b expected 0", c, bus.o_m_valid);
            end
        end
        bus.i_s_a = lane0(32'd5); bus.i_s_b = lane0(32'd6); bus.i_s_valid = 1'b1;
        tick();
        bus.i_s_valid = 1'b0;
        checks++;
        if (bus.o_m_valid !== 1'b0) begin
            errors++; $display("FAIL rm_early got %b expected 0", bus.o_m_valid);
        end
        tick();
        checks++;
        if ({bus.o_m_valid, bus.o_m_data} !== {1'b1, lane0(32'd11)}) begin
            errors++; $display("FAIL rm_after got v=%b lane0=%h expected v=1 lane0=0000000b",
                               bus.o_m_valid, bus.o_m_data[31:0]);
        end
        tick();
    endtask

    task automatic test_chunk32();
        bus32.i_s_a = 32'h80000000; bus32.i_s_b = 32'h80000000; bus32.i_s_op = 1'b0;
        bus32.i_s_last = 1'b0; bus32.i_m_ready = 1'b1; bus32.i_s_valid = 1'b1;
        tick();
        bus32.i_s_valid = 1'b0;
        checks++;
        if ({bus32.o_m_valid, bus32.o_m_carry, bus32.o_m_data} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL c32_result got v=%b c=%b d=%h expected v=1 c=1 d=00000000",
                               bus32.o_m_valid, bus32.o_m_carry, bus32.o_m_data);
        end
        tick();
        checks++;
        if (bus32.o_m_valid !== 1'b0) begin
            errors++; $display("FAIL c32_drained got %b expected 0", bus32.o_m_valid);
        end
    endtask

    task automatic test_chunk8();
        bus8.i_s_a = 32'h00FFFFFF; bus8.i_s_b = 32'h00000001; bus8.i_s_op = 1'b0;
        bus8.i_s_last = 1'b0; bus8.i_m_ready = 1'b1; bus8.i_s_valid = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            tick();
            bus8.i_s_valid = 1'b0;
            checks++;
            if (bus8.o_m_valid !== (p == 4)) begin
                errors++; $display("FAIL c8_latency edge=%0d got %b expected %b", p, bus8.o_m_valid, (p == 4));
            end
        end
        checks++;
        if ({bus8.o_m_carry, bus8.o_m_data} !== {1'b0, 32'h01000000}) begin
            errors++; $display("FAIL c8_result got c=%b d=%h expected c=0 d=01000000",
                               bus8.o_m_carry, bus8.o_m_data);
        end
        tick();
    endtask

    initial begin
        bus.i_s_valid = 1'b0; bus.i_s_op = 1'b0; bus.i_s_a = '0; bus.i_s_b = '0;
        bus.i_s_last = 1'b0; bus.i_m_ready = 1'b1;
        bus32.i_s_valid = 1'b0; bus32.i_s_op = 1'b0; bus32.i_s_a = '0; bus32.i_s_b = '0;
        bus32.i_s_last = 1'b0; bus32.i_m_ready = 1'b1;
        bus8.i_s_valid = 1'b0; bus8.i_s_op = 1'b0; bus8.i_s_a = '0; bus8.i_s_b = '0;
        bus8.i_s_last = 1'b0; bus8.i_m_ready = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_cross_chunk();
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        test_chunk32();
        test_chunk8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
